reg_file_param: RTL and testbench

- Parametrised successor to the fixed 16x32 ARM-style register file: configurable data width and register count, 3 read ports (Rn, Rs, Rm) plus an Rd readback, and one write port.
- Adds a dedicated PC register with stall control, branch-by-write to the PC index, a link-register write port, and an optional write-to-read bypass.
- Sits between decode and execute in the CPU datapath.

---
 rtl/reg_file_param_if.sv | 35 +++
 rtl/reg_file_param.sv | 99 +++++++++
 tb/tb_reg_file_param.sv | 379 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_param_if.sv
// Bus bundle for reg_file_param: write port, three read ports plus Rd readback,
// PC advance/stall controls and the link-register write request.
interface reg_file_param_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  logic              write_enable_ARd;
  logic [ADDR_W-1:0] Rd_Address;
  logic [DATA_W-1:0] Rd_data;
  logic [ADDR_W-1:0] Rn_Address;
  logic [ADDR_W-1:0] Rs_Address;
  logic [ADDR_W-1:0] Rm_Address;
  logic [DATA_W-1:0] Rn;
  logic [DATA_W-1:0] Rs;
  logic [DATA_W-1:0] Rm;
  logic [DATA_W-1:0] Rd;
  logic              pc_enable;
  logic [DATA_W-1:0] PC_next;
  logic              link_enable;
  logic [DATA_W-1:0] PC_out;

  modport master (
    output write_enable_ARd, Rd_Address, Rd_data,
    output Rn_Address, Rs_Address, Rm_Address,
    output pc_enable, PC_next, link_enable,
    input  Rn, Rs, Rm, Rd, PC_out
  );

  modport slave (
    input  write_enable_ARd, Rd_Address, Rd_data,
    input  Rn_Address, Rs_Address, Rm_Address,
    input  pc_enable, PC_next, link_enable,
    output Rn, Rs, Rm, Rd, PC_out
  );
endinterface

// File: rtl/reg_file_param.sv
// Parametrised register file with a dedicated PC, branch-by-write, link write and 3 read ports.
// Defining REG_FILE_BYPASS_EN adds write-first forwarding on Rn/Rs/Rm.
module reg_file_param #(
  parameter int DATA_W         = 32,
  parameter int NUM_REGS       = 16,
  parameter int ADDR_W         = 4,
  parameter int PC_INDEX       = 15,
  parameter int LR_INDEX       = 14,
  parameter int RESET_PC       = 0,
  parameter int PC_READ_OFFSET = 8
) (
  input  logic               clk,
  input  logic               reset,
  reg_file_param_if.slave    bus
);

  localparam logic [ADDR_W-1:0] PC_ADDR      = ADDR_W'(PC_INDEX);
  localparam logic [ADDR_W-1:0] LR_ADDR      = ADDR_W'(LR_INDEX);
  localparam logic [DATA_W-1:0] PC_RESET_VAL = DATA_W'(RESET_PC);
  localparam logic [DATA_W-1:0] PC_OFFSET    = DATA_W'(PC_READ_OFFSET);
  localparam logic [DATA_W-1:0] LINK_OFFSET  = DATA_W'(4);
  localparam bit                LR_IN_RANGE  = (LR_INDEX < NUM_REGS);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] pc;
  logic [DATA_W-1:0] pc_read_value;
  logic [DATA_W-1:0] link_value;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_write_reg;
  logic              rd_write_pc;

  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return int'(addr) < NUM_REGS;
  endfunction

  function automatic logic [DATA_W-1:0] stored_read(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] value;
    value = '0;
    if (addr == PC_ADDR) begin
      value = pc_read_value;
    end else if (in_range(addr)) begin
      value = regs[addr];
    end
    return value;
  endfunction

  // Forwarding only covers writes that will actually land in the array.
  function automatic logic [DATA_W-1:0] port_read(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] value;
    value = stored_read(addr);
`ifdef REG_FILE_BYPASS_EN
    if (rd_write_reg && addr == wr_addr) begin
      value = wr_data;
    end else if (LR_IN_RANGE && bus.link_enable && addr == LR_ADDR && addr != PC_ADDR) begin
      value = link_value;
    end
`endif
    return value;
  endfunction

  assign wr_addr       = bus.Rd_Address;
  assign wr_data       = bus.Rd_data;
  assign pc_read_value = pc + PC_OFFSET;
  assign link_value    = pc + LINK_OFFSET;
  assign rd_write_pc   = bus.write_enable_ARd && (wr_addr == PC_ADDR);
  assign rd_write_reg  = bus.write_enable_ARd && (wr_addr != PC_ADDR) && in_range(wr_addr);

  // The Rd write is placed after the link write so it wins an LR collision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      pc <= PC_RESET_VAL;
    end else begin
      if (rd_write_pc) begin
        pc <= wr_data;
      end else if (bus.pc_enable) begin
        pc <= bus.PC_next;
      end
      if (LR_IN_RANGE && bus.link_enable) begin
        regs[LR_ADDR] <= link_value;
      end
      if (rd_write_reg) begin
        regs[wr_addr] <= wr_data;
      end
    end
  end

  always_comb begin
    bus.Rn     = port_read(bus.Rn_Address);
    bus.Rs     = port_read(bus.Rs_Address);
    bus.Rm     = port_read(bus.Rm_Address);
    bus.Rd     = stored_read(bus.Rd_Address);
    bus.PC_out = pc;
  end

endmodule

// File: tb/tb_reg_file_param.sv
// Self-checking bench for reg_file_param: default 16x32 instance plus a narrow
// 12-entry 8-bit instance for out-of-range and wrap-around behaviour.
module tb_reg_file_param;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  reg_file_param_if #(.DATA_W(32), .ADDR_W(4)) bus ();
  reg_file_param_if #(.DATA_W(8),  .ADDR_W(4)) bus_s ();

  reg_file_param #(
    .DATA_W(32), .NUM_REGS(16), .ADDR_W(4), .PC_INDEX(15),
    .LR_INDEX(14), .RESET_PC(0), .PC_READ_OFFSET(8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  reg_file_param #(
    .DATA_W(8), .NUM_REGS(12), .ADDR_W(4), .PC_INDEX(11),
    .LR_INDEX(10), .RESET_PC(253), .PC_READ_OFFSET(8)
  ) dut_s (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_s)
  );

  int          total  = 0;
  int          passed = 0;
  logic [31:0] exp_q[$];
  logic [31:0] m_regs[16];
  logic [31:0] m_pc;

  task automatic idle();
    bus.write_enable_ARd   = 1'b0;
    bus.Rd_Address         = '0;
    bus.Rd_data            = '0;
    bus.Rn_Address         = '0;
    bus.Rs_Address         = '0;
    bus.Rm_Address         = '0;
    bus.pc_enable          = 1'b0;
    bus.PC_next            = '0;
    bus.link_enable        = 1'b0;
    bus_s.write_enable_ARd = 1'b0;
    bus_s.Rd_Address       = '0;
    bus_s.Rd_data          = '0;
    bus_s.Rn_Address       = '0;
    bus_s.Rs_Address       = '0;
    bus_s.Rm_Address       = '0;
    bus_s.pc_enable        = 1'b0;
    bus_s.PC_next          = '0;
    bus_s.link_enable      = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] exp;
    reset = 1'b1;
    #2;
    bus.Rn_Address = 4'd0;
    bus.Rs_Address = 4'd5;
    bus.Rm_Address = 4'd15;
    bus.Rd_Address = 4'd9;
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd8);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd0);
    #1;
    exp = exp_q.pop_front(); total++;
    if (bus.Rn !== exp) $display("[TB] FAIL reset_rn: got %0h expected %0h", bus.Rn, exp); else passed++;
    exp = exp_q.pop_front(); total++;
    if (bus.Rs !== exp) $display("[TB] FAIL reset_rs: got %0h expected %0h", bus.Rs, exp); else passed++;
    exp = exp_q.pop_front(); total++;
    if (bus.Rm !== exp) $display("[TB] FAIL reset_rm_pc_read: got %0h expected %0h", bus.Rm, exp); else passed++;
    exp = exp_q.pop_front(); total++;
    if (bus.Rd !== exp) $display("[TB] FAIL reset_rd: got %0h expected %0h", bus.Rd, exp); else passed++;
    exp = exp_q.pop_front(); total++;
    if (bus.PC_out !== exp) $display("[TB] FAIL reset_pc: got %0h expected %0h", bus.PC_out, exp); else passed++;
    reset = 1'b0;
    idle();
  endtask

  task automatic test_write_read();
    logic [31:0] exp;
    bus.write_enable_ARd = 1'b1;
    bus.Rd_Address       = 4'd6;
    bus.Rd_data          = 32'd34;
    exp_q.push_back(32'd34);
    tick();
    idle();
    bus.Rn_Address = 4'd6;
    #1;
    exp = exp_q.pop_front(); total++;
    if (bus.Rn !== exp) $display("[TB] FAIL write_read_r6: got %0d expected %0d", bus.Rn, exp); else passed++;
    bus.Rd_Address = 4'd6;
    bus.Rd_data    = 32'd38;
    exp_q.push_back(32'd34);
    exp_q.push_back(32'd34);
    tick();
    bus.Rn_Address = 4'd6;
    #1;
    exp = exp_q.pop_front(); total++;
    if (bus.Rn !== exp) $display("[TB] FAIL write_disabled_r6: got %0d expected %0d", bus.Rn, exp); else passed++;
    exp = exp_q.pop_front(); total++;
    if (bus.Rd !== exp) $display("[TB] FAIL rd_readback_r6: got %0d expected %0d", bus.Rd, exp); else passed++;
    idle();
  endtask

  task automatic test_pc_stall();
    logic [31:0] exp;
    bus.pc_enable = 1'b1;
    bus.PC_next   = 32'd4;
    exp_q.push_back(32'd4);
    tick();
    exp = exp_q.pop_front(); total++;
    if (bus.PC_out !== exp) $display("[TB] FAIL pc_advance: got %0h expected %0h", bus.PC_out, exp); else passed++;
    bus.pc_enable = 1'b0;
    bus.PC_next   = 32'd5;
    exp_q.push_back(32'd4);
    exp_q.push_back(32'd12);
    tick();
    bus.Rs_Address = 4'd15;
    #1;
    exp = exp_q.pop_front(); total++;
    if (bus.PC_out !== exp) $display("[TB] FAIL pc_stall: got %0h expected %0h", bus.PC_out, exp); else passed++;
    exp = exp_q.pop_front(); total++;
    if (bus.Rs !== exp) $display("[TB] FAIL pc_read_offset: got %0h expected %0h", bus.Rs, exp); else passed++;
    idle();
  endtask

  task automatic test_branch();
    logic [31:0] exp;
    bus.pc_enable        = 1'b1;
    bus.PC_next          = 32'd7;
    bus.write_enable_ARd = 1'b1;
    bus.Rd_Address       = 4'd15;
    bus.Rd_data          = 32'h100;
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h108);
    tick();
    idle();
    bus.Rm_Address = 4'd15;
    #1;
    exp = exp_q.pop_front(); total++;
    if (bus.PC_out !== exp) $display("[TB] FAIL branch_priority: got %0h expected %0h", bus.PC_out, exp); else passed++;
    exp = exp_q.pop_front(); total++;
    if (bus.Rm !== exp) $display("[TB] FAIL branch_pc_read: got %0h expected %0h", bus.Rm, exp); else passed++;
  endtask

  task automatic test_link();
    logic [31:0] exp;
    bus.write_enable_ARd = 1'b1;
    bus.Rd_Address       = 4'd15;
    bus.Rd_data          = 32'h20;
    tick();
    idle();
    bus.link_enable = 1'b1;
    exp_q.push_back(32'h24);
    tick();
    idle();
    bus.Rn_Address = 4'd14;
    #1;
    exp = exp_q.pop_front(); total++;
    if (bus.Rn !== exp) $display("[TB] FAIL link_write: got %0h expected %0h", bus.Rn, exp); else passed++;
    bus.link_enable      = 1'b1;
    bus.write_enable_ARd = 1'b1;
    bus.Rd_Address       = 4'd14;
    bus.Rd_data          = 32'd99;
    exp_q.push_back(32'd99);
    tick();
    idle();
    bus.Rn_Address = 4'd14;
    #1;
    exp = exp_q.pop_front(); total++;
    if (bus.Rn !== exp) $display("[TB] FAIL link_collision: got %0h expected %0h", bus.Rn, exp); else passed++;
    // Link plus branch on one edge: LR captures the pre-branch PC.
    bus.link_enable      = 1'b1;
    bus.write_enable_ARd = 1'b1;
    bus.Rd_Address       = 4'd15;
    bus.Rd_data          = 32'h40;
    exp_q.push_back(32'h24);
    exp_q.push_back(32'h40);
    tick();
    idle();
    bus.Rn_Address = 4'd14;
    #1;
    exp = exp_q.pop_front(); total++;
    if (bus.Rn !== exp) $display("[TB] FAIL link_branch_lr: got %0h expected %0h", bus.Rn, exp); else passed++;
    exp = exp_q.pop_front(); total++;
    if (bus.PC_out !== exp) $display("[TB] FAIL link_branch_pc: got %0h expected %0h", bus.PC_out, exp); else passed++;
  endtask

  task automatic test_bypass();
    logic [31:0] exp;
    bus.write_enable_ARd = 1'b1;
    bus.Rd_Address       = 4'd3;
    bus.Rd_data          = 32'd11;
    tick();
    idle();
    bus.write_enable_ARd = 1'b1;
    bus.Rd_Address       = 4'd3;
    bus.Rd_data          = 32'd173;
    bus.Rm_Address       = 4'd3;
    bus.link_enable      = 1'b1;
    bus.Rs_Address       = 4'd14;
`ifdef REG_FILE_BYPASS_EN
    exp_q.push_back(32'd173);
    exp_q.push_back(32'h44);
`else
    exp_q.push_back(32'd11);
    exp_q.push_back(32'h24);
`endif
    exp_q.push_back(32'd11);
    #1;
    exp = exp_q.pop_front(); total++;
    if (bus.Rm !== exp) $display("[TB] FAIL bypass_rm_same_cycle: got %0d expected %0d", bus.Rm, exp); else passed++;
    exp = exp_q.pop_front(); total++;
    if (bus.Rs !== exp) $display("[TB] FAIL bypass_link_same_cycle: got %0h expected %0h", bus.Rs, exp); else passed++;
    exp = exp_q.pop_front(); total++;
    if (bus.Rd !== exp) $display("[TB] FAIL rd_not_bypassed: got %0d expected %0d", bus.Rd, exp); else passed++;
    exp_q.push_back(32'd173);
    exp_q.push_back(32'h44);
    tick();
    idle();
    bus.Rm_Address = 4'd3;
    bus.Rs_Address = 4'd14;
    #1;
    exp = exp_q.pop_front(); total++;
    if (bus.Rm !== exp) $display("[TB] FAIL bypass_rm_after_edge: got %0d expected %0d", bus.Rm, exp); else passed++;
    exp = exp_q.pop_front(); total++;
    if (bus.Rs !== exp) $display("[TB] FAIL link_after_edge: got %0h expected %0h", bus.Rs, exp); else passed++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] exp;
    bus.write_enable_ARd = 1'b1;
    bus.Rd_Address       = 4'd2;
    bus.Rd_data          = 32'd77;
    bus.pc_enable        = 1'b1;
    bus.PC_next          = 32'h99;
    bus.Rn_Address       = 4'd3;
    reset                = 1'b1;
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd0);
    #1;
    exp = exp_q.pop_front(); total++;
    if (bus.PC_out !== exp) $display("[TB] FAIL async_reset_pc: got %0h expected %0h", bus.PC_out, exp); else passed++;
    exp = exp_q.pop_front(); total++;
    if (bus.Rn !== exp) $display("[TB] FAIL async_reset_r3: got %0d expected %0d", bus.Rn, exp); else passed++;
    tick();
    idle();
    reset = 1'b0;
    bus.Rn_Address = 4'd2;
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd0);
    #1;
    exp = exp_q.pop_front(); total++;
    if (bus.Rn !== exp) $display("[TB] FAIL reset_drops_write: got %0d expected %0d", bus.Rn, exp); else passed++;
    exp = exp_q.pop_front(); total++;
    if (bus.PC_out !== exp) $display("[TB] FAIL reset_drops_pc: got %0h expected %0h", bus.PC_out, exp); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    logic [3:0]  addr;
    logic [31:0] data;
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    m_pc = '0;
    for (int i = 0; i < 10; i++) begin
      addr = 4'($urandom_range(0, 13));
      data = $urandom;
      bus.write_enable_ARd = 1'b1;
      bus.Rd_Address       = addr;
      bus.Rd_data          = data;
      bus.pc_enable        = 1'b1;
      bus.PC_next          = 32'(i * 4 + 16);
      m_regs[addr]         = data;
      m_pc                 = 32'(i * 4 + 16);
      tick();
    end
    idle();
    exp_q.push_back(m_pc);
    #1;
    exp = exp_q.pop_front(); total++;
    if (bus.PC_out !== exp) $display("[TB] FAIL b2b_pc: got %0h expected %0h", bus.PC_out, exp); else passed++;
    for (int a = 0; a < 14; a++) begin
      bus.Rn_Address = 4'(a);
      bus.Rs_Address = 4'((a + 1) % 14);
      bus.Rm_Address = 4'((a + 2) % 14);
      exp_q.push_back(m_regs[a]);
      exp_q.push_back(m_regs[(a + 1) % 14]);
      exp_q.push_back(m_regs[(a + 2) % 14]);
      @(negedge clk);
      exp = exp_q.pop_front(); total++;
      if (bus.Rn !== exp) $display("[TB] FAIL b2b_rn[%0d]: got %0h expected %0h", a, bus.Rn, exp); else passed++;
      exp = exp_q.pop_front(); total++;
      if (bus.Rs !== exp) $display("[TB] FAIL b2b_rs[%0d]: got %0h expected %0h", a, bus.Rs, exp); else passed++;
      exp = exp_q.pop_front(); total++;
      if (bus.Rm !== exp) $display("[TB] FAIL b2b_rm[%0d]: got %0h expected %0h", a, bus.Rm, exp); else passed++;
    end
    idle();
  endtask

  // Narrow instance: PC 253 wraps on both the +8 read and the +4 link.
  task automatic test_small_config();
    logic [31:0] exp;
    bus_s.Rn_Address = 4'd11;
    exp_q.push_back(32'd253);
    exp_q.push_back(32'd5);
    #1;
    exp = exp_q.pop_front(); total++;
    if (32'(bus_s.PC_out) !== exp) $display("[TB] FAIL small_reset_pc: got %0d expected %0d", bus_s.PC_out, exp); else passed++;
    exp = exp_q.pop_front(); total++;
    if (32'(bus_s.Rn) !== exp) $display("[TB] FAIL small_pc_read_wrap: got %0d expected %0d", bus_s.Rn, exp); else passed++;
    bus_s.write_enable_ARd = 1'b1;
    bus_s.Rd_Address       = 4'd13;
    bus_s.Rd_data          = 8'h55;
    bus_s.link_enable      = 1'b1;
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd1);
    tick();
    idle();
    bus_s.Rn_Address = 4'd13;
    bus_s.Rd_Address = 4'd13;
    bus_s.Rm_Address = 4'd10;
    #1;
    exp = exp_q.pop_front(); total++;
    if (32'(bus_s.Rn) !== exp) $display("[TB] FAIL small_oor_read: got %0h expected %0h", bus_s.Rn, exp); else passed++;
    exp = exp_q.pop_front(); total++;
    if (32'(bus_s.Rd) !== exp) $display("[TB] FAIL small_oor_rd: got %0h expected %0h", bus_s.Rd, exp); else passed++;
    exp = exp_q.pop_front(); total++;
    if (32'(bus_s.Rm) !== exp) $display("[TB] FAIL small_link_wrap: got %0h expected %0h", bus_s.Rm, exp); else passed++;
    bus_s.write_enable_ARd = 1'b1;
    bus_s.Rd_Address       = 4'd5;
    bus_s.Rd_data          = 8'hA5;
    bus_s.pc_enable        = 1'b1;
    bus_s.PC_next          = 8'hFF;
    exp_q.push_back(32'hA5);
    exp_q.push_back(32'hFF);
    exp_q.push_back(32'd7);
    tick();
    idle();
    bus_s.Rn_Address = 4'd5;
    bus_s.Rs_Address = 4'd11;
    #1;
    exp = exp_q.pop_front(); total++;
    if (32'(bus_s.Rn) !== exp) $display("[TB] FAIL small_write_r5: got %0h expected %0h", bus_s.Rn, exp); else passed++;
    exp = exp_q.pop_front(); total++;
    if (32'(bus_s.PC_out) !== exp) $display("[TB] FAIL small_pc_advance: got %0h expected %0h", bus_s.PC_out, exp); else passed++;
    exp = exp_q.pop_front(); total++;
    if (32'(bus_s.Rs) !== exp) $display("[TB] FAIL small_pc_read_ff: got %0h expected %0h", bus_s.Rs, exp); else passed++;
    idle();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_write_read();
    test_pc_stall();
    test_branch();
    test_link();
    test_bypass();
    test_reset_mid();
    test_back_to_back();
    test_small_config();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
